// File: rtl/date_pkg.sv
// Shared calendar tables, leap-year rule, default widths and FSM state type
// for the sequential date-difference block.
package date_pkg;

   localparam int YEAR_W_DEF = 12;
   localparam int DIFF_W_DEF = 21;
   localparam int MON_W_DEF  = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CONV_A = 2'd1,
      ST_CONV_B = 2'd2,
      ST_DIFF   = 2'd3
   } state_t;

   // Indexed directly by the raw 4-bit month; out-of-range months read as 0.
   localparam logic [8:0] CUM_DAYS [0:15] = '{
      9'd0,   9'd0,   9'd31,  9'd59,  9'd90,  9'd120, 9'd151, 9'd181,
      9'd212, 9'd243, 9'd273, 9'd304, 9'd334, 9'd0,   9'd0,   9'd0
   };

   localparam logic [4:0] DAYS_IN_MONTH [0:15] = '{
      5'd0,  5'd31, 5'd28, 5'd31, 5'd30, 5'd31, 5'd30, 5'd31,
      5'd31, 5'd30, 5'd31, 5'd30, 5'd31, 5'd0,  5'd0,  5'd0
   };

   function automatic logic is_leap(input logic [31:0] y);
      return ((y % 32'd4 == 32'd0) && (y % 32'd100 != 32'd0)) || (y % 32'd400 == 32'd0);
   endfunction

endpackage

// File: rtl/date_diff_seq_if.sv
// Start/done handshake plus the two input dates and the result bus.
interface date_diff_seq_if
   import date_pkg::*;
#(
   parameter int YEAR_W = YEAR_W_DEF,
   parameter int DIFF_W = DIFF_W_DEF,
   parameter int MON_W  = MON_W_DEF
);
   logic              start;
   logic [4:0]        day1;
   logic [3:0]        mon1;
   logic [YEAR_W-1:0] year1;
   logic [4:0]        day2;
   logic [3:0]        mon2;
   logic [YEAR_W-1:0] year2;
   logic              busy;
   logic              done;
   logic              err;
   logic              neg;
   logic [DIFF_W-1:0] day_diff;
   logic [MON_W-1:0]  mon_diff;

   modport master (
      output start, day1, mon1, year1, day2, mon2, year2,
      input  busy, done, err, neg, day_diff, mon_diff
   );

   modport slave (
      input  start, day1, mon1, year1, day2, mon2, year2,
      output busy, done, err, neg, day_diff, mon_diff
   );
endinterface

// File: rtl/date_to_ordinal.sv
// Combinational Gregorian day-ordinal (1/1/1 -> 1) with date validity check.
module date_to_ordinal
   import date_pkg::*;
#(
   parameter int YEAR_W = YEAR_W_DEF,
   parameter int DIFF_W = DIFF_W_DEF
)(
   input  logic [4:0]        day,
   input  logic [3:0]        mon,
   input  logic [YEAR_W-1:0] year,
   output logic [DIFF_W:0]   ordinal,
   output logic              valid
);
   localparam int OW = DIFF_W + 1;

   logic [OW-1:0] ym1;
   logic          leap;
   logic [4:0]    mon_len;

   always_comb begin
      ym1     = OW'(year) - OW'(1);
      leap    = is_leap(32'(year));
      mon_len = DAYS_IN_MONTH[mon] + 5'(leap && (mon == 4'd2));
      // year==0 wraps ym1; the result is discarded because valid is low then
      ordinal = ym1 * OW'(365) + ym1 / OW'(4) - ym1 / OW'(100) + ym1 / OW'(400)
              + OW'(CUM_DAYS[mon]) + OW'(leap && (mon > 4'd2)) + OW'(day);
      valid   = (year != '0) && (mon != 4'd0) && (mon <= 4'd12)
              && (day != 5'd0) && (day <= mon_len);
   end
endmodule

// File: rtl/date_diff_seq.sv
// Sequential absolute day/month difference between two dates, sharing one
// ordinal converter across both dates over a fixed four-cycle sequence.
module date_diff_seq
   import date_pkg::*;
#(
   parameter int YEAR_W = YEAR_W_DEF,
   parameter int DIFF_W = DIFF_W_DEF,
   parameter int MON_W  = MON_W_DEF
)(
   input logic           clk,
   input logic           rst,
   date_diff_seq_if.slave bus
);
   localparam int OW = DIFF_W + 1;
   localparam int MW = MON_W + 1;

   state_t            state_reg, state_next;
   logic [4:0]        day_reg  [2], day_next  [2];
   logic [3:0]        mon_reg  [2], mon_next  [2];
   logic [YEAR_W-1:0] year_reg [2], year_next [2];
   logic [OW-1:0]     ord_reg  [2], ord_next  [2];
   logic              bad_reg, bad_next;
   logic              done_reg, done_next;
   logic              err_reg, err_next;
   logic              neg_reg, neg_next;
   logic [DIFF_W-1:0] day_diff_reg, day_diff_next;
   logic [MON_W-1:0]  mon_diff_reg, mon_diff_next;

   logic              sel_b;
   logic [OW-1:0]     conv_ord;
   logic              conv_valid;
   logic [MW-1:0]     midx_a, midx_b;

   assign sel_b = (state_reg == ST_CONV_B);

   date_to_ordinal #(.YEAR_W(YEAR_W), .DIFF_W(DIFF_W)) u_conv (
      .day     (sel_b ? day_reg[1]  : day_reg[0]),
      .mon     (sel_b ? mon_reg[1]  : mon_reg[0]),
      .year    (sel_b ? year_reg[1] : year_reg[0]),
      .ordinal (conv_ord),
      .valid   (conv_valid)
   );

   // Month index ignores the day fields entirely
   assign midx_a = MW'(year_reg[0]) * MW'(12) + MW'(mon_reg[0]);
   assign midx_b = MW'(year_reg[1]) * MW'(12) + MW'(mon_reg[1]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= ST_IDLE;
         bad_reg      <= 1'b0;
         done_reg     <= 1'b0;
         err_reg      <= 1'b0;
         neg_reg      <= 1'b0;
         day_diff_reg <= '0;
         mon_diff_reg <= '0;
         for (int i = 0; i < 2; i++) begin
            day_reg[i]  <= '0;
            mon_reg[i]  <= '0;
            year_reg[i] <= '0;
            ord_reg[i]  <= '0;
         end
      end else begin
         state_reg    <= state_next;
         bad_reg      <= bad_next;
         done_reg     <= done_next;
         err_reg      <= err_next;
         neg_reg      <= neg_next;
         day_diff_reg <= day_diff_next;
         mon_diff_reg <= mon_diff_next;
         for (int i = 0; i < 2; i++) begin
            day_reg[i]  <= day_next[i];
            mon_reg[i]  <= mon_next[i];
            year_reg[i] <= year_next[i];
            ord_reg[i]  <= ord_next[i];
         end
      end
   end

   always_comb begin
      state_next    = state_reg;
      day_next      = day_reg;
      mon_next      = mon_reg;
      year_next     = year_reg;
      ord_next      = ord_reg;
      bad_next      = bad_reg;
      done_next     = 1'b0;
      err_next      = err_reg;
      neg_next      = neg_reg;
      day_diff_next = day_diff_reg;
      mon_diff_next = mon_diff_reg;

      unique case (state_reg)
         ST_IDLE: begin
            if (bus.start) begin
               day_next[0]  = bus.day1;
               mon_next[0]  = bus.mon1;
               year_next[0] = bus.year1;
               day_next[1]  = bus.day2;
               mon_next[1]  = bus.mon2;
               year_next[1] = bus.year2;
               bad_next     = 1'b0;
               err_next     = 1'b0;
               state_next   = ST_CONV_A;
            end
         end
         ST_CONV_A: begin
            ord_next[0] = conv_ord;
            bad_next    = ~conv_valid;
            state_next  = ST_CONV_B;
         end
         ST_CONV_B: begin
            ord_next[1] = conv_ord;
            bad_next    = bad_reg | ~conv_valid;
            state_next  = ST_DIFF;
         end
         ST_DIFF: begin
            done_next  = 1'b1;
            state_next = ST_IDLE;
            if (bad_reg) begin
               err_next      = 1'b1;
               neg_next      = 1'b0;
               day_diff_next = '0;
               mon_diff_next = '0;
            end else begin
               neg_next      = (ord_reg[1] < ord_reg[0]);
               day_diff_next = (ord_reg[1] < ord_reg[0]) ? DIFF_W'(ord_reg[0] - ord_reg[1])
                                                         : DIFF_W'(ord_reg[1] - ord_reg[0]);
               mon_diff_next = (midx_b < midx_a) ? MON_W'(midx_a - midx_b)
                                                 : MON_W'(midx_b - midx_a);
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign bus.busy     = (state_reg != ST_IDLE);
   assign bus.done     = done_reg;
   assign bus.err      = err_reg;
   assign bus.neg      = neg_reg;
   assign bus.day_diff = day_diff_reg;
   assign bus.mon_diff = mon_diff_reg;
endmodule

// File: tb/tb_date_diff_seq.sv
// Scoreboard bench for date_diff_seq: directed calendar corners plus random
// dates, checked against a day-counting reference model.
module tb_date_diff_seq;
   import date_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   txn_id = 0;
   bit   prev_done = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   date_diff_seq_if #(.YEAR_W(12), .DIFF_W(21), .MON_W(16)) bus ();

   date_diff_seq #(.YEAR_W(12), .DIFF_W(21), .MON_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      longint ddiff;
      longint mdiff;
      bit     neg;
      bit     err;
      int     acc_cyc;
      int     id;
   } exp_t;

   exp_t sb[$];

   function automatic void check(input string what, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", what, act, exp);
      end
   endfunction

   // Reference model: counts whole years and months day by day
   function automatic bit m_leap(input int y);
      return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
   endfunction

   function automatic int m_mlen(input int m, input int y);
      case (m)
         1, 3, 5, 7, 8, 10, 12: return 31;
         4, 6, 9, 11:           return 30;
         2:                     return m_leap(y) ? 29 : 28;
         default:               return 0;
      endcase
   endfunction

   function automatic bit m_valid(input int d, input int m, input int y);
      return (y >= 1) && (m >= 1) && (m <= 12) && (d >= 1) && (d <= m_mlen(m, y));
   endfunction

   function automatic longint m_ord(input int d, input int m, input int y);
      longint n = 0;
      for (int yy = 1; yy < y; yy++) n += m_leap(yy) ? 366 : 365;
      for (int mm = 1; mm < m; mm++) n += m_mlen(mm, y);
      return n + d;
   endfunction

   function automatic exp_t model(input int d1, input int m1, input int y1,
                                  input int d2, input int m2, input int y2);
      exp_t   e;
      longint na, nb, ma, mb;
      e.acc_cyc = 0;
      e.id      = 0;
      if (!m_valid(d1, m1, y1) || !m_valid(d2, m2, y2)) begin
         e.err = 1'b1; e.neg = 1'b0; e.ddiff = 0; e.mdiff = 0;
      end else begin
         na = m_ord(d1, m1, y1);
         nb = m_ord(d2, m2, y2);
         ma = longint'(y1) * 12 + m1;
         mb = longint'(y2) * 12 + m2;
         e.err   = 1'b0;
         e.neg   = (nb < na);
         e.ddiff = (nb < na) ? na - nb : nb - na;
         e.mdiff = (mb < ma) ? ma - mb : mb - ma;
      end
      return e;
   endfunction

   task automatic drive(input int d1, input int m1, input int y1,
                        input int d2, input int m2, input int y2);
      bus.day1  = 5'(d1);
      bus.mon1  = 4'(m1);
      bus.year1 = 12'(y1);
      bus.day2  = 5'(d2);
      bus.mon2  = 4'(m2);
      bus.year2 = 12'(y2);
   endtask

   // Returns right after the edge on which the DIFF step completes, so the
   // next call lands its start in the done cycle (back-to-back).
   task automatic issue(input int d1, input int m1, input int y1,
                        input int d2, input int m2, input int y2, input bit poke);
      exp_t e;
      @(negedge clk);
      drive(d1, m1, y1, d2, m2, y2);
      bus.start = 1'b1;
      e = model(d1, m1, y1, d2, m2, y2);
      @(posedge clk); #1;
      bus.start = 1'b0;
      e.acc_cyc = cyc;
      e.id      = txn_id++;
      sb.push_back(e);
      if (poke) begin
         @(posedge clk); #1;
         check("busy_in_conv_b", bus.busy, 1);
         drive(1, 1, 100, 31, 12, 3000);
         bus.start = 1'b1;
         @(posedge clk); #1;
         bus.start = 1'b0;
         @(posedge clk);
      end else begin
         repeat (3) @(posedge clk);
      end
   endtask

   task automatic pick(output int d, output int m, output int y);
      int r;
      r = int'($urandom_range(0, 19));
      y = int'($urandom_range(1, 4095));
      if (r == 0) y = 0;
      if (r == 1) y = 400 * int'($urandom_range(1, 10));
      if (r == 2) y = 100 * int'($urandom_range(1, 40));
      m = (r == 3) ? int'($urandom_range(13, 15)) : (r == 4) ? 0 : int'($urandom_range(1, 12));
      d = (r == 5) ? 0 : (r >= 6 && r <= 9) ? int'($urandom_range(28, 31))
                                            : int'($urandom_range(1, 28));
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents done
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         prev_done = 1'b0;
      end else begin
         if (bus.done) begin
            check("done_single_cycle", prev_done, 0);
            if (sb.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               e = sb.pop_front();
               $display("txn %0d: day_diff=%0d mon_diff=%0d neg=%0d err=%0d",
                        e.id, bus.day_diff, bus.mon_diff, bus.neg, bus.err);
               check("latency", cyc - e.acc_cyc, 3);
               check("busy_at_done", bus.busy, 0);
               check("err", bus.err, e.err);
               check("neg", bus.neg, e.neg);
               check("day_diff", bus.day_diff, e.ddiff);
               check("mon_diff", bus.mon_diff, e.mdiff);
            end
         end
         prev_done = bus.done;
      end
   end

   initial begin
      rst       = 1'b1;
      bus.start = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_err", bus.err, 0);
      check("rst_neg", bus.neg, 0);
      check("rst_day_diff", bus.day_diff, 0);
      check("rst_mon_diff", bus.mon_diff, 0);
      rst = 1'b0;

      issue(1, 1, 2024, 31, 12, 2024, 0);
      issue(28, 2, 1900, 1, 3, 1900, 0);
      issue(28, 2, 2000, 1, 3, 2000, 0);
      issue(28, 2, 2024, 1, 3, 2024, 0);
      issue(31, 12, 2024, 1, 1, 2023, 0);
      issue(15, 3, 2024, 15, 3, 2024, 0);
      issue(29, 2, 2023, 1, 1, 2023, 0);
      issue(0, 5, 2020, 1, 1, 2021, 0);
      issue(1, 1, 2020, 1, 13, 2020, 0);
      issue(1, 1, 0, 1, 1, 2020, 0);
      issue(10, 6, 2010, 20, 8, 2015, 1);
      issue(1, 1, 1, 31, 12, 4095, 0);

      // Abort in DIFF: outputs clear asynchronously and no done follows
      @(negedge clk);
      drive(5, 5, 2005, 6, 6, 2006);
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort_busy", bus.busy, 0);
      check("abort_done", bus.done, 0);
      check("abort_err", bus.err, 0);
      check("abort_neg", bus.neg, 0);
      check("abort_day_diff", bus.day_diff, 0);
      check("abort_mon_diff", bus.mon_diff, 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);

      for (int t = 0; t < 40; t++) begin
         int d1, m1, y1, d2, m2, y2;
         pick(d1, m1, y1);
         pick(d2, m2, y2);
         issue(d1, m1, y1, d2, m2, y2, 0);
      end

      repeat (8) @(negedge clk);
      while (sb.size() != 0) begin
         exp_t e;
         e = sb.pop_front();
         check("missing_done_txn", e.id, -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
